// File: rtl/lamp_fpu_log_round_pack_if.sv
// ----------------------------------------------------------------------------
// Module  : lamp_fpu_log_round_pack_if
// Brief   : Log-result input, control and buffered-output bundle for the
//           round/pack stage.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface lamp_fpu_log_round_pack_if #(
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int FIFO_DEPTH      = 2
);
  logic                                    valid_i;
  logic                                    s_res_i;
  logic [LAMP_FLOAT_E_DW-1:0]              e_res_i;
  logic [LAMP_FLOAT_F_DW-1:0]              f_res_i;
  logic                                    isOverflow_i;
  logic                                    isUnderflow_i;
  logic                                    isToRound_i;
  logic                                    flush_i;
  logic                                    clear_flags_i;
  logic                                    ready_i;
  logic                                    valid_o;
  logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] result_o;
  logic [$clog2(FIFO_DEPTH+1)-1:0]         count_o;
  logic [2:0]                              fflags_o;
  logic                                    drop_o;

  modport master (
    output valid_i, s_res_i, e_res_i, f_res_i, isOverflow_i, isUnderflow_i,
           isToRound_i, flush_i, clear_flags_i, ready_i,
    input  valid_o, result_o, count_o, fflags_o, drop_o
  );

  modport slave (
    input  valid_i, s_res_i, e_res_i, f_res_i, isOverflow_i, isUnderflow_i,
           isToRound_i, flush_i, clear_flags_i, ready_i,
    output valid_o, result_o, count_o, fflags_o, drop_o
  );
endinterface

`default_nettype wire

// File: rtl/lamp_fpu_log_round_pack.sv
// ----------------------------------------------------------------------------
// Module  : lamp_fpu_log_round_pack
// Brief   : Rounds, saturates and packs log-unit results into bfloat16 words,
//           buffering them in a small FIFO with sticky exception flags.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lamp_fpu_log_round_pack #(
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int FIFO_DEPTH      = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  lamp_fpu_log_round_pack_if.slave  bus
);
  localparam int c_mag_w  = LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
  localparam int c_word_w = 1 + c_mag_w;
  localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(FIFO_DEPTH - 1);

  logic [c_mag_w-1:0]         w_sum;
  logic [LAMP_FLOAT_E_DW-1:0] w_sum_exp;
  logic [c_word_w-1:0]        w_word;
  logic [2:0]                 w_flags;

  // Flags are {OF,UF,NX}; overflow wins over underflow.
  always_comb begin
    w_sum     = {bus.e_res_i, bus.f_res_i} + c_mag_w'(bus.isToRound_i);
    w_sum_exp = w_sum[c_mag_w-1:LAMP_FLOAT_F_DW];
    w_word    = {bus.s_res_i, w_sum};
    w_flags   = {2'b00, bus.isToRound_i};
    if (bus.isOverflow_i || (&w_sum_exp)) begin
      w_word  = {bus.s_res_i, {LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
      w_flags = 3'b101;
    end else if (bus.isUnderflow_i) begin
      w_word  = {bus.s_res_i, {c_mag_w{1'b0}}};
      w_flags = 3'b011;
    end
  end

  logic                r_pipe_vld;
  logic [c_word_w-1:0] r_pipe_word;
  logic [2:0]          r_pipe_flags;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_vld   <= 1'b0;
      r_pipe_word  <= '0;
      r_pipe_flags <= '0;
    end else begin
      r_pipe_vld <= bus.valid_i & ~bus.flush_i;
      if (bus.valid_i) begin
        r_pipe_word  <= w_word;
        r_pipe_flags <= w_flags;
      end
    end
  end

  logic [c_word_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [2:0]          r_fflags;
  logic                r_drop;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == c_full);
    w_pop   = w_valid & bus.ready_i;
    w_push  = r_pipe_vld & (~w_full | w_pop);
    w_drop  = r_pipe_vld & w_full & ~w_pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_pipe_word;
        r_wptr        <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A same-cycle set overrides clear; a flush suppresses both set sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fflags <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_fflags <= (bus.clear_flags_i ? 3'b000 : r_fflags)
                | ((w_push & ~bus.flush_i) ? r_pipe_flags : 3'b000);
      r_drop   <= (bus.clear_flags_i ? 1'b0 : r_drop) | (w_drop & ~bus.flush_i);
    end
  end

  assign bus.valid_o  = w_valid;
  assign bus.result_o = w_valid ? r_mem[r_rptr] : '0;
  assign bus.count_o  = r_count;
  assign bus.fflags_o = r_fflags;
  assign bus.drop_o   = r_drop;
endmodule

`default_nettype wire

// File: tb/tb_lamp_fpu_log_round_pack.sv
// ----------------------------------------------------------------------------
// Module  : tb_lamp_fpu_log_round_pack
// Brief   : Scoreboard bench for the log round/pack stage.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lamp_fpu_log_round_pack;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [15:0] sb [$];

  lamp_fpu_log_round_pack_if #(.LAMP_FLOAT_E_DW(8), .LAMP_FLOAT_F_DW(7), .FIFO_DEPTH(2)) bus ();

  lamp_fpu_log_round_pack #(
    .LAMP_FLOAT_E_DW(8),
    .LAMP_FLOAT_F_DW(7),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] model(input logic s, input logic [7:0] e, input logic [6:0] f,
                                        input logic of, input logic uf, input logic rnd);
    logic [14:0] mag;
    mag = {e, f} + {14'd0, rnd};
    if (of || mag[14:7] == 8'hFF) return {s, 8'hFF, 7'h00};
    if (uf) return {s, 15'h0000};
    return {s, mag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [6:0] f,
                      input logic of, input logic uf, input logic rnd, input logic keep);
    bus.s_res_i       = s;
    bus.e_res_i       = e;
    bus.f_res_i       = f;
    bus.isOverflow_i  = of;
    bus.isUnderflow_i = uf;
    bus.isToRound_i   = rnd;
    bus.valid_i       = 1'b1;
    if (keep) sb.push_back(model(s, e, f, of, uf, rnd));
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_count(input int target, input string tag);
    int n;
    n = 0;
    while (int'(bus.count_o) != target && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.count_o), 32'(target));
  endtask

  task automatic clear_flags();
    bus.clear_flags_i = 1'b1;
    tick();
    bus.clear_flags_i = 1'b0;
  endtask

  // Output side of the scoreboard: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (rst && bus.valid_o && bus.ready_i && !bus.flush_i) begin
      if (sb.size() == 0) check("sb_underrun", 32'(sb.size()), 32'd1);
      else check("sb_result", 32'(bus.result_o), 32'(sb.pop_front()));
    end
  end

  initial begin
    logic [7:0] e;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.s_res_i = 1'b0; bus.e_res_i = '0; bus.f_res_i = '0;
    bus.isOverflow_i = 1'b0; bus.isUnderflow_i = 1'b0; bus.isToRound_i = 1'b0;
    bus.flush_i = 1'b0; bus.clear_flags_i = 1'b0; bus.ready_i = 1'b0;

    #22;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_result", 32'(bus.result_o), 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_fflags", 32'(bus.fflags_o), 32'd0);
    check("rst_drop", 32'(bus.drop_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // T1: carry from fraction into exponent, two-cycle latency
    bus.ready_i = 1'b1;
    send(1'b0, 8'h85, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_lat1", 32'(bus.valid_o), 32'd0);
    tick();
    check("t1_lat2", 32'(bus.valid_o), 32'd1);
    check("t1_word", 32'(bus.result_o), 32'h4300);
    check("t1_flags", 32'(bus.fflags_o), 32'b001);
    tick();

    // T2: rounding into infinity, then underflow
    send(1'b0, 8'hFE, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    check("t2_of_flags", 32'(bus.fflags_o), 32'b101);
    send(1'b1, 8'h10, 7'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    check("t2_uf_flags", 32'(bus.fflags_o), 32'b111);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // T3: overfill with no consumer
    clear_flags();
    check("t3_flags_clr", 32'(bus.fflags_o), 32'd0);
    bus.ready_i = 1'b0;
    send(1'b0, 8'h40, 7'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b1, 8'h41, 7'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h42, 7'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("t3_count_full", 32'(bus.count_o), 32'd2);
    check("t3_drop", 32'(bus.drop_o), 32'd1);
    check("t3_no_nx", 32'(bus.fflags_o), 32'd0);
    bus.ready_i = 1'b1;
    wait_count(0, "t3_drain");
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // T4: full FIFO streaming with simultaneous push and pop
    clear_flags();
    bus.ready_i = 1'b0;
    send(1'b0, 8'h50, 7'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b1, 8'h51, 7'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("t4_prefill", 32'(bus.count_o), 32'd2);
    for (int i = 2; i < 8; i++) begin
      e = 8'($urandom_range(1, 253));
      bus.s_res_i = 1'($urandom); bus.e_res_i = e; bus.f_res_i = 7'($urandom);
      bus.isOverflow_i = 1'b0; bus.isUnderflow_i = 1'b0; bus.isToRound_i = 1'($urandom);
      bus.valid_i = 1'b1;
      bus.ready_i = (i > 2);
      sb.push_back(model(bus.s_res_i, bus.e_res_i, bus.f_res_i, 1'b0, 1'b0, bus.isToRound_i));
      tick();
      if (i > 2) check("t4_count", 32'(bus.count_o), 32'd2);
    end
    bus.valid_i = 1'b0;
    tick();
    check("t4_count_last", 32'(bus.count_o), 32'd2);
    check("t4_no_drop", 32'(bus.drop_o), 32'd0);
    wait_count(0, "t4_drain");
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // T5: clear coinciding with an overflow push, then flush of a full FIFO
    clear_flags();
    send(1'b0, 8'h20, 7'h05, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("t5_uf", 32'(bus.fflags_o), 32'b011);
    send(1'b1, 8'h30, 7'h06, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.clear_flags_i = 1'b1;
    tick();
    bus.clear_flags_i = 1'b0;
    check("t5_clr_set", 32'(bus.fflags_o), 32'b101);
    tick(); tick();
    bus.ready_i = 1'b0;
    send(1'b0, 8'h60, 7'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h61, 7'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_count(2, "t5_full");
    bus.s_res_i = 1'b0; bus.e_res_i = 8'h62; bus.f_res_i = 7'h09;
    bus.isOverflow_i = 1'b0; bus.isUnderflow_i = 1'b0; bus.isToRound_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("t5_flush_valid", 32'(bus.valid_o), 32'd0);
    check("t5_flush_count", 32'(bus.count_o), 32'd0);
    check("t5_flush_flags", 32'(bus.fflags_o), 32'b101);
    tick(); tick();
    check("t5_inflight_gone", 32'(bus.valid_o), 32'd0);
    bus.ready_i = 1'b1;
    send(1'b1, 8'h70, 7'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // T6: asynchronous reset in the middle of a cycle with a full FIFO
    bus.ready_i = 1'b0;
    send(1'b0, 8'h11, 7'h0B, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 8'h12, 7'h0C, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_count(2, "t6_full");
    #3;
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(bus.valid_o), 32'd0);
    check("t6_count", 32'(bus.count_o), 32'd0);
    check("t6_flags", 32'(bus.fflags_o), 32'd0);
    check("t6_result", 32'(bus.result_o), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    bus.ready_i = 1'b1;
    send(1'b0, 8'h85, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("t6_after_flags", 32'(bus.fflags_o), 32'b001);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
